che_hist_clip_mc: RTL and testbench

Time-multiplexed, parametrised successor to the four-instance parallel clip stage. Clips and redistributes CLAHE tile histograms for CH_NUM channels (ul/ur/bl/br at default) through one shared serial datapath. The block clips each bin to a per-channel limit, accumulates the excess and redistributes it uniformly, including the residual. It sits between the histogram statistics stage and the CDF/mapping stage. It adds three things the previous block did not have: a valid/ready handshake, round-robin arbitration and a bypass mode.

---
 rtl/che_hist_clip_mc_if.sv | 18 +
 rtl/che_hist_clip_mc.sv | 134 +++++++++++++
 tb/tb_che_hist_clip_mc.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/che_hist_clip_mc_if.sv
// Request/response bundle for the shared CLAHE clip stage.
// Flat vectors keep the packing identical to the legacy per-channel buses.
interface che_hist_clip_mc_if #(
    parameter int CH_NUM  = 4,
    parameter int BIN_NUM = 256,
    parameter int BIN_WD  = 12,
    parameter int CLIP_WD = 12
);
    logic [CH_NUM-1:0]                vld_i;
    logic [CH_NUM-1:0]                rdy_o;
    logic [CH_NUM*CLIP_WD-1:0]        clip_i;
    logic [CH_NUM*BIN_NUM*BIN_WD-1:0] hist_i;
    logic [CH_NUM-1:0]                vld_o;
    logic [CH_NUM*BIN_NUM*BIN_WD-1:0] hist_o;

    modport master (output vld_i, clip_i, hist_i, input rdy_o, vld_o, hist_o);
    modport slave  (input vld_i, clip_i, hist_i, output rdy_o, vld_o, hist_o);
endinterface

// File: rtl/che_hist_clip_mc.sv
// Round-robin shared CLAHE histogram clip + uniform excess redistribution.
// One bin per cycle: BIN_NUM clip cycles, BIN_NUM redistribution cycles, one done cycle.
module che_hist_clip_mc #(
    parameter int CH_NUM  = 4,
    parameter int BIN_NUM = 256,
    parameter int BIN_WD  = 12,
    parameter int CLIP_WD = 12,
    parameter int IDX_WD  = $clog2(BIN_NUM),
    parameter int EXC_WD  = BIN_WD + IDX_WD,
    parameter int CH_WD   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input logic               clk,
    input logic               rstn,
    che_hist_clip_mc_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CLIP, DIST, DONE} state_t;

    state_t                                     state;
    logic [IDX_WD-1:0]                          idx;
    logic [EXC_WD-1:0]                          exc;
    logic [CLIP_WD-1:0]                         clip_q;
    logic [CH_WD-1:0]                           ch_q;
    logic [CH_WD-1:0]                           rr_ptr;
    logic [BIN_NUM-1:0][BIN_WD-1:0]             work;
    logic [CH_NUM-1:0][BIN_NUM-1:0][BIN_WD-1:0] hist_q;
    logic [CH_NUM-1:0][BIN_NUM-1:0][BIN_WD-1:0] hist_in;
    logic [CH_NUM-1:0][CLIP_WD-1:0]             clip_in;
    logic [CH_NUM-1:0]                          vld_q;
    logic [CH_NUM-1:0]                          rdy;

    assign hist_in    = bus.hist_i;
    assign clip_in    = bus.clip_i;
    assign bus.hist_o = hist_q;
    assign bus.vld_o  = vld_q;
    assign bus.rdy_o  = rdy;

    // Descending scan so the requester closest to the pointer wins.
    logic [CH_WD-1:0] gnt;
    logic [CH_WD-1:0] cand;
    logic             gnt_any;
    always_comb begin
        gnt     = '0;
        cand    = '0;
        gnt_any = 1'b0;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            cand = CH_WD'((int'(rr_ptr) + i) % CH_NUM);
            if (bus.vld_i[cand]) begin
                gnt     = cand;
                gnt_any = 1'b1;
            end
        end
    end

    // Gated by rstn so no grant is advertised while the block is held in reset.
    always_comb begin
        rdy = '0;
        if (rstn && state == IDLE && gnt_any) rdy[gnt] = 1'b1;
    end

    logic accept;
    assign accept = |(rdy & bus.vld_i);

    logic                last;
    logic [BIN_WD-1:0]   cur;
    logic [BIN_WD-1:0]   clip_ext;
    logic [BIN_WD-1:0]   avg;
    logic                res_bit;
    logic                over;
    logic [BIN_WD+1:0]   dsum;
    logic [BIN_WD-1:0]   bin_new;

    assign last     = (idx == IDX_WD'(BIN_NUM - 1));
    assign cur      = work[idx];
    assign clip_ext = BIN_WD'(clip_q);
    assign over     = (clip_q != '0) && (cur > clip_ext);
    assign avg      = exc[EXC_WD-1:IDX_WD];
    assign res_bit  = (idx < exc[IDX_WD-1:0]);
    assign dsum     = {2'b00, cur} + {2'b00, avg} + {{(BIN_WD+1){1'b0}}, res_bit};

    always_comb begin
        bin_new = cur;
        case (state)
            CLIP: if (over) bin_new = clip_ext;
            DIST: if (exc != '0) bin_new = (dsum[BIN_WD+1:BIN_WD] != 2'b00) ? '1 : dsum[BIN_WD-1:0];
            default: bin_new = cur;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            idx    <= '0;
            exc    <= '0;
            clip_q <= '0;
            ch_q   <= '0;
            rr_ptr <= '0;
            work   <= '0;
            hist_q <= '0;
            vld_q  <= '0;
        end else begin
            vld_q <= '0;
            case (state)
                IDLE: if (accept) begin
                    work   <= hist_in[gnt];
                    clip_q <= clip_in[gnt];
                    ch_q   <= gnt;
                    exc    <= '0;
                    idx    <= '0;
                    rr_ptr <= (gnt == CH_WD'(CH_NUM - 1)) ? '0 : gnt + 1'b1;
                    state  <= CLIP;
                end
                CLIP: begin
                    work[idx] <= bin_new;
                    if (over) exc <= exc + EXC_WD'(cur - clip_ext);
                    idx <= idx + 1'b1;
                    if (last) state <= DIST;
                end
                DIST: begin
                    work[idx] <= bin_new;
                    idx       <= idx + 1'b1;
                    // Publish on the last bin so vld_o is visible during the DONE cycle.
                    if (last) begin
                        for (int k = 0; k < BIN_NUM; k++)
                            hist_q[ch_q][k] <= (k == BIN_NUM - 1) ? bin_new : work[k];
                        vld_q[ch_q] <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_che_hist_clip_mc.sv
// Directed + randomized bench for che_hist_clip_mc against an arithmetic clip/redistribute model.
module tb_che_hist_clip_mc;
    localparam int CH = 4, BN = 8, BW = 8, CW = 8, W = BN * BW;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    che_hist_clip_mc_if #(.CH_NUM(CH), .BIN_NUM(BN), .BIN_WD(BW), .CLIP_WD(CW)) bus();

    che_hist_clip_mc #(.CH_NUM(CH), .BIN_NUM(BN), .BIN_WD(BW), .CLIP_WD(CW)) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    int vecs = 0, errs = 0;
    int in_h[CH][BN];
    int in_c[CH];
    int exp_o[CH][BN];
    int hv[BN];

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] pack(input int h[BN]);
        logic [W-1:0] p;
        for (int k = 0; k < BN; k++) p[k*BW +: BW] = BW'(h[k]);
        return p;
    endfunction

    task automatic load(input int ch, input int clip);
        for (int k = 0; k < BN; k++) begin
            in_h[ch][k] = hv[k];
            bus.hist_i[(ch*BN+k)*BW +: BW] = BW'(hv[k]);
        end
        in_c[ch] = clip;
        bus.clip_i[ch*CW +: CW] = CW'(clip);
    endtask

    // Clip, then spread excess evenly with the remainder going to the lowest bins.
    task automatic model(input int ch);
        int ex = 0;
        int v;
        for (int k = 0; k < BN; k++) begin
            if (in_c[ch] != 0 && in_h[ch][k] > in_c[ch]) begin
                ex += in_h[ch][k] - in_c[ch];
                exp_o[ch][k] = in_c[ch];
            end else exp_o[ch][k] = in_h[ch][k];
        end
        for (int k = 0; k < BN; k++) begin
            v = exp_o[ch][k] + ex / BN + ((k < ex % BN) ? 1 : 0);
            exp_o[ch][k] = (v > 2**BW - 1) ? 2**BW - 1 : v;
        end
    endtask

    task automatic clear_model();
        for (int c = 0; c < CH; c++) for (int k = 0; k < BN; k++) exp_o[c][k] = 0;
    endtask

    task automatic check_all(input string tag);
        logic [W-1:0] e;
        for (int c = 0; c < CH; c++) begin
            for (int k = 0; k < BN; k++) e[k*BW +: BW] = BW'(exp_o[c][k]);
            chk($sformatf("%s ch%0d", tag, c), bus.hist_o[c*W +: W], e);
        end
    endtask

    // Entered and left at negedge+1; exp_wait = expected cycles until the grant.
    task automatic serve(input int ch, input int exp_wait);
        int n = 0;
        int lat = 1;
        #1;
        while (bus.rdy_o == '0 && n < 200) begin @(negedge clk); #1; n++; end
        chk($sformatf("grant ch%0d", ch), W'(bus.rdy_o), W'(1 << ch));
        if (exp_wait >= 0) chk($sformatf("wait ch%0d", ch), W'(n), W'(exp_wait));
        @(negedge clk);
        bus.vld_i[ch] = 1'b0;
        #1;
        while (!bus.vld_o[ch] && lat < 200) begin @(negedge clk); #1; lat++; end
        chk($sformatf("latency ch%0d", ch), W'(lat), W'(2 * BN + 1));
        chk($sformatf("vld_o ch%0d", ch), W'(bus.vld_o), W'(1 << ch));
        model(ch);
        check_all("hist");
        @(negedge clk); #1;
        chk($sformatf("pulse ch%0d", ch), W'(bus.vld_o), '0);
    endtask

    initial begin
        logic seen;
        int ch, clip;
        bus.vld_i  = '0;
        bus.clip_i = '0;
        bus.hist_i = '0;
        clear_model();

        // Reset state, with requests pending.
        @(negedge clk); #1;
        bus.vld_i = '1; #1;
        chk("rst rdy_o", W'(bus.rdy_o), '0);
        chk("rst vld_o", W'(bus.vld_o), '0);
        check_all("rst");
        bus.vld_i = '0;
        @(negedge clk); rstn = 1'b1; #1;

        hv = '{10, 0, 0, 0, 0, 0, 0, 0}; load(0, 4); bus.vld_i[0] = 1'b1; serve(0, 0);
        hv = '{5, 1, 1, 1, 1, 1, 0, 0};  chk("tp1 const", bus.hist_o[0*W +: W], pack(hv));
        hv = '{20, 20, 0, 0, 0, 0, 0, 0}; load(1, 6); bus.vld_i[1] = 1'b1; serve(1, 0);
        hv = '{10, 10, 4, 4, 3, 3, 3, 3}; chk("tp2 const", bus.hist_o[1*W +: W], pack(hv));
        hv = '{3, 3, 3, 3, 3, 3, 3, 3};  load(2, 4); bus.vld_i[2] = 1'b1; serve(2, 0);
        chk("noexc const", bus.hist_o[2*W +: W], pack(hv));
        hv = '{9, 1, 0, 0, 0, 0, 0, 0};  load(3, 0); bus.vld_i[3] = 1'b1; serve(3, 0);
        chk("bypass const", bus.hist_o[3*W +: W], pack(hv));

        // All four requesting from reset: accepts at 0,18,36,54.
        rstn = 1'b0; clear_model(); #1;
        for (int c = 0; c < CH; c++) begin
            for (int k = 0; k < BN; k++) hv[k] = $urandom_range(0, 40);
            load(c, $urandom_range(1, 12));
        end
        bus.vld_i = '1; #1;
        chk("rst2 rdy_o", W'(bus.rdy_o), '0);
        check_all("rst2");
        @(negedge clk); rstn = 1'b1;
        for (int c = 0; c < CH; c++) serve(c, 0);

        // Fairness: after ch2, pointer sits at 3 and wraps to ch0 before ch2.
        for (int k = 0; k < BN; k++) hv[k] = $urandom_range(0, 60);
        load(2, 5); bus.vld_i = 4'b0100; serve(2, 0);
        for (int k = 0; k < BN; k++) hv[k] = $urandom_range(0, 60);
        load(0, 7);
        for (int k = 0; k < BN; k++) hv[k] = $urandom_range(0, 60);
        load(2, 9);
        bus.vld_i = 4'b0101;
        serve(0, 0);
        serve(2, 0);

        // Reset during CLIP cycle 3 of a ch0 job.
        for (int k = 0; k < BN; k++) hv[k] = $urandom_range(0, 80);
        load(0, 6); bus.vld_i[0] = 1'b1; #1;
        chk("midrst grant", W'(bus.rdy_o), W'(1));
        @(negedge clk); bus.vld_i[0] = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        rstn = 1'b0; clear_model(); #1;
        chk("midrst rdy_o", W'(bus.rdy_o), '0);
        chk("midrst vld_o", W'(bus.vld_o), '0);
        check_all("midrst");
        seen = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (i == 2) rstn = 1'b1;
            @(negedge clk); #1;
            if (bus.vld_o != '0) seen = 1'b1;
        end
        chk("midrst no vld", W'(seen), '0);
        for (int k = 0; k < BN; k++) hv[k] = $urandom_range(0, 80);
        load(0, 6); bus.vld_i[0] = 1'b1; serve(0, 0);

        // Randomized single-channel jobs, including bypass and no-clip cases.
        for (int it = 0; it < 20; it++) begin
            ch = $urandom_range(0, CH - 1);
            for (int k = 0; k < BN; k++) hv[k] = $urandom_range(0, 255);
            clip = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 255);
            load(ch, clip);
            bus.vld_i[ch] = 1'b1;
            serve(ch, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
